// File: rtl/mips_defs.sv
// Shared definitions for the instruction-memory loader.
// State encodings and byte width used by the loader and its helpers.
package mips_defs;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERR    = 3'd6
  } ld_state_t;

endpackage

// File: rtl/word_assembler.sv
// Packs a byte stream into big-endian words.
// First byte lands in the top byte; full flags the final byte of a word.
module word_assembler
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] data,
  output logic [WIDTH-1:0]  word,
  output logic              full
);

  localparam int NB = WIDTH / BYTE_W;
  localparam int IW = $clog2(NB);

  logic [WIDTH-BYTE_W-1:0] acc;
  logic [IW-1:0]           idx;

  // word already includes the byte on the input, so it is valid when full
  assign word = {acc, data};
  assign full = shift && (idx == IW'(NB - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
      idx <= '0;
    end else if (shift) begin
      acc <= word[WIDTH-BYTE_W-1:0];
      idx <= full ? '0 : idx + IW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads instruction memory from a counted byte stream,
// holding the core in reset until the program is in place.
module imem_loader
  import mips_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       byte_valid,
  input  logic [BYTE_W-1:0]          byte_data,
  output logic                       byte_ready,
  output logic                       imem_we,
  output logic [WIDTH-1:0]           imem_addr,
  output logic [WIDTH-1:0]           imem_wd,
  output logic                       core_hold,
  output logic                       done,
  output logic                       error,
  output logic [$clog2(DEPTH):0]     words_loaded
);

  localparam int ADDR_W = $clog2(DEPTH);

  ld_state_t         state;
  logic [15:0]       cnt;
  logic [ADDR_W:0]   word_idx;
  logic [WIDTH-1:0]  asm_word;
  logic              asm_full;
  logic              xfer;
  logic              idle_like;
  logic              restart;
  logic              shift;
  logic [15:0]       hdr_cnt;

  assign xfer      = byte_valid && byte_ready;
  assign idle_like = (state == S_IDLE) || (state == S_DONE)
                  || (state == S_ERR);
  assign restart   = start && idle_like;
  assign shift     = xfer && (state == S_DATA);
  assign hdr_cnt   = {cnt[15:8], byte_data};

  assign words_loaded = word_idx;

  word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .shift (shift),
    .data  (byte_data),
    .word  (asm_word),
    .full  (asm_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      word_idx   <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wd    <= '0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state      <= S_HDR_HI;
            byte_ready <= 1'b1;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_idx   <= '0;
            cnt        <= '0;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            cnt[15:8] <= byte_data;
            state     <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            cnt <= hdr_cnt;
            if (hdr_cnt == 16'd0) begin
              state      <= S_DONE;
              byte_ready <= 1'b0;
              core_hold  <= 1'b0;
              done       <= 1'b1;
            end else if (hdr_cnt > 16'(DEPTH)) begin
              state      <= S_ERR;
              byte_ready <= 1'b0;
              error      <= 1'b1;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (asm_full) begin
            state      <= S_WRITE;
            byte_ready <= 1'b0;
            imem_we    <= 1'b1;
            imem_addr  <= WIDTH'(word_idx) << 2;
            imem_wd    <= asm_word;
          end
        end
        S_WRITE: begin
          word_idx <= word_idx + (ADDR_W + 1)'(1);
          if (16'(word_idx) + 16'd1 == cnt) begin
            state     <= S_DONE;
            core_hold <= 1'b0;
            done      <= 1'b1;
          end else begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued
// by the stimulus and popped by a monitor on every imem_we pulse.
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 64;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [6:0]  words_loaded;

  wr_t exp_q[$];
  wr_t exp_e;
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_we_cyc = -1;
  int  n_writes = 0;
  int  w0;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wd      (imem_wd),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the queue.
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      n_writes++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                 imem_addr, imem_wd);
      end else begin
        exp_e = exp_q.pop_front();
        check("write_addr", imem_addr, exp_e.addr);
        check("write_data", imem_wd, exp_e.wd);
      end
    end
  end

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.wd   = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !byte_ready; i++) @(negedge clk);
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL byte_ready_timeout: got 0 expected 1 (byte %0h)", b);
    end
    @(posedge clk);
  endtask

  task automatic gap();
    @(negedge clk);
    byte_valid = 1'b0;
    @(posedge clk);
  endtask

  // With toggle set, valid drops for a cycle between bytes except
  // right after the last byte of a word, so it stays high across WRITE.
  task automatic send_stream(input logic [7:0] q[$], input bit toggle);
    for (int j = 0; j < q.size(); j++) begin
      send(q[j]);
      if (toggle && j != q.size() - 1 && !(j >= 2 && (j - 2) % 4 == 3))
        gap();
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    check("done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t2[$];
    logic [7:0] s[$];
    t2 = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
           8'hAC, 8'h08, 8'h00, 8'h00};

    // 1: reset values
    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wd", imem_wd, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_words", words_loaded, 0);
    reset = 1'b0;

    // 2: two-word load
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC080000);
    pulse_start();
    check("t2_hold_loading", core_hold, 1);
    send_stream(t2, 1'b0);
    wait_done();
    check("t2_done_latency", cyc - last_we_cyc, 1);
    check("t2_core_hold", core_hold, 0);
    check("t2_words", words_loaded, 2);
    check("t2_queue_empty", exp_q.size(), 0);

    // 3: zero-length program
    w0 = n_writes;
    pulse_start();
    check("t3_done_cleared", done, 0);
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    wait_done();
    check("t3_no_writes", n_writes - w0, 0);
    check("t3_words", words_loaded, 0);
    check("t3_core_hold", core_hold, 0);

    // 4: oversized header, then recovery
    w0 = n_writes;
    pulse_start();
    s = '{8'h00, 8'h41};
    send_stream(s, 1'b0);
    @(negedge clk);
    check("t4_error", error, 1);
    check("t4_byte_ready", byte_ready, 0);
    check("t4_core_hold", core_hold, 1);
    check("t4_done", done, 0);
    check("t4_no_writes", n_writes - w0, 0);
    expect_write(32'h0, 32'hDEADBEEF);
    pulse_start();
    check("t4_error_cleared", error, 0);
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_stream(s, 1'b0);
    wait_done();
    check("t4_words", words_loaded, 1);
    check("t4_queue_empty", exp_q.size(), 0);

    // 5: toggling valid
    expect_write(32'h0, 32'h20080005);
    expect_write(32'h4, 32'hAC080000);
    pulse_start();
    send_stream(t2, 1'b1);
    wait_done();
    check("t5_words", words_loaded, 2);
    check("t5_queue_empty", exp_q.size(), 0);

    // 6: reset mid-load discards partial word
    w0 = n_writes;
    pulse_start();
    s = '{8'h00, 8'h02, 8'hAA, 8'hBB};
    send_stream(s, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_core_hold", core_hold, 1);
    check("t6_byte_ready", byte_ready, 0);
    check("t6_words", words_loaded, 0);
    check("t6_no_writes", n_writes - w0, 0);
    expect_write(32'h0, 32'h11223344);
    pulse_start();
    s = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(s, 1'b0);
    wait_done();
    check("t6_words_after", words_loaded, 1);
    check("t6_queue_empty", exp_q.size(), 0);

    // 7: cnt == DEPTH fills the whole memory
    s = '{8'h00, 8'h40};
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] k;
      k = 8'(i);
      s.push_back(k);
      s.push_back(~k);
      s.push_back(k ^ 8'h80);
      s.push_back(8'h5A);
      expect_write(32'(i) << 2, {k, ~k, k ^ 8'h80, 8'h5A});
    end
    pulse_start();
    send_stream(s, 1'b0);
    wait_done();
    check("t7_words", words_loaded, 64);
    check("t7_last_addr", imem_addr, 32'hFC);
    check("t7_error", error, 0);
    check("t7_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
